alu_op_scheduler: RTL and testbench

Shares the registered four-function ALU datapath (mul/add/div/sub, one-hot select, two register stages) among `NREQ` requesters. It arbitrates requests round-robin and drives the ALU's one-hot select and operands for exactly the two cycles an operation needs. Outside those cycles it holds operands and select at zero, which provides operand isolation for low-power flows. It captures the result and returns it to the winning requester over a valid/ready response channel.

---
 rtl/alu_op_scheduler_pkg.sv | 33 +++
 rtl/alu_op_scheduler_rr_arbiter.sv | 28 ++
 rtl/alu_op_scheduler.sv | 153 +++++++++++++++
 tb/tb_alu_op_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_scheduler_pkg.sv
// Shared opcode, select and state definitions for the ALU operation scheduler.
package alu_sched_pkg;

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  localparam logic [3:0] SEL_MUL = 4'b1000;
  localparam logic [3:0] SEL_ADD = 4'b0100;
  localparam logic [3:0] SEL_DIV = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0001;

  localparam logic [7:0] DIV0_RESULT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC1,
    ST_EXEC2,
    ST_CAP,
    ST_RESP
  } state_e;

  function automatic logic [3:0] op_to_sel(input logic [1:0] op);
    case (op)
      OP_MUL:  return SEL_MUL;
      OP_ADD:  return SEL_ADD;
      OP_DIV:  return SEL_DIV;
      default: return SEL_SUB;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt
);

  localparam int unsigned IW = $clog2(NREQ);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IW'((32'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares a two-stage registered ALU among NREQ requesters; one operation in flight,
// ALU inputs held at zero outside the two execute cycles.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4,
  parameter int unsigned OW   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [W*NREQ-1:0]       req_a,
  input  logic [W*NREQ-1:0]       req_b,
  output logic [NREQ-1:0]         gnt,
  output logic [W-1:0]            alu_a,
  output logic [W-1:0]            alu_b,
  output logic [3:0]              alu_sel,
  input  logic [OW-1:0]           alu_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [OW-1:0]           rsp_data,
  output logic                    rsp_err
);

  localparam int unsigned IW = $clog2(NREQ);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [W-1:0]  alu_a_q, alu_a_d;
  logic [W-1:0]  alu_b_q, alu_b_d;
  logic [3:0]    alu_sel_q, alu_sel_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [OW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  logic [NREQ-1:0] pick;
  logic [IW-1:0]   pick_idx;
  logic [1:0]      pick_op;
  logic [W-1:0]    pick_a;
  logic [W-1:0]    pick_b;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick)
  );

  always_comb begin
    pick_idx = '0;
    pick_op  = '0;
    pick_a   = '0;
    pick_b   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        pick_idx = IW'(i);
        pick_op  = req_op[2*i +: 2];
        pick_a   = req_a[W*i +: W];
        pick_b   = req_b[W*i +: W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    gnt         = '0;
    case (state_q)
      ST_IDLE: begin
        // gnt is combinational, so it is masked while reset is held.
        if (|pick && rst) begin
          gnt   = pick;
          id_d  = pick_idx;
          ptr_d = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
          if (pick_op == OP_DIV && pick_b == '0) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = OW'(DIV0_RESULT);
          end else begin
            state_d   = ST_EXEC1;
            rsp_err_d = 1'b0;
            alu_sel_d = op_to_sel(pick_op);
            alu_a_d   = pick_a;
            alu_b_d   = pick_b;
          end
        end
      end
      ST_EXEC1: state_d = ST_EXEC2;
      ST_EXEC2: begin
        state_d   = ST_CAP;
        alu_sel_d = '0;
        alu_a_d   = '0;
        alu_b_d   = '0;
      end
      ST_CAP: begin
        state_d     = ST_RESP;
        rsp_data_d  = alu_out;
        rsp_valid_d = 1'b1;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed scoreboard bench for alu_op_scheduler with a two-stage ALU model.
module tb_alu_op_scheduler;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [7:0]  req_op = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [3:0]  gnt;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_out;
  logic [7:0]  alu_s1;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  alu_op_scheduler #(.NREQ(4), .W(4), .OW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .gnt       (gnt),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  function automatic logic [7:0] ref_result(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] ea, eb;
    ea = {4'h0, a};
    eb = {4'h0, b};
    case (op)
      2'b00:   return ea * eb;
      2'b01:   return ea + eb;
      2'b10:   return (eb == 8'd0) ? 8'hFF : ea / eb;
      default: return ea - eb;
    endcase
  endfunction

  function automatic logic [7:0] alu_comb(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
    case (sel)
      4'b1000: return ref_result(2'b00, a, b);
      4'b0100: return ref_result(2'b01, a, b);
      4'b0010: return ref_result(2'b10, a, b);
      4'b0001: return ref_result(2'b11, a, b);
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_s1  <= 8'h00;
      alu_out <= 8'h00;
    end else begin
      alu_s1  <= alu_comb(alu_sel, alu_a, alu_b);
      alu_out <= alu_s1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic collect(input string tag);
    exp_t e;
    check({tag, "_pending"}, 32'(sbq.size() != 0), 32'd1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check({tag, "_id"},   32'(rsp_id),   32'(e.id));
      check({tag, "_data"}, 32'(rsp_data), 32'(e.data));
      check({tag, "_err"},  32'(rsp_err),  32'(e.err));
    end
  endtask

  task automatic push_exp(input int id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e.id   = 2'(id);
    e.err  = (op == 2'b10 && b == 4'd0);
    e.data = ref_result(op, a, b);
    sbq.push_back(e);
  endtask

  task automatic set_req(input int id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    req[id]            = 1'b1;
    req_op[2*id +: 2]  = op;
    req_a[4*id +: 4]   = a;
    req_b[4*id +: 4]   = b;
  endtask

  task automatic chk_iso(input string tag);
    check({tag, "_sel"}, 32'(alu_sel), 32'd0);
    check({tag, "_a"},   32'(alu_a),   32'd0);
    check({tag, "_b"},   32'(alu_b),   32'd0);
  endtask

  task automatic run_op(input int id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
    bit dz;
    dz = (op == 2'b10 && b == 4'd0);
    push_exp(id, op, a, b);
    @(negedge clk);
    chk_iso("idle");
    set_req(id, op, a, b);
    #1;
    check("gnt", 32'(gnt), 32'(1 << id));
    @(negedge clk);
    req[id] = 1'b0;
    if (dz) begin
      chk_iso("dz_c1");
      check("dz_valid_c1", 32'(rsp_valid), 32'd1);
      collect("dz");
    end else begin
      check("exec1_sel", 32'(alu_sel), 32'(sel));
      check("exec1_a", 32'(alu_a), 32'(a));
      check("exec1_b", 32'(alu_b), 32'(b));
      check("exec1_gnt", 32'(gnt), 32'd0);
      @(negedge clk);
      check("exec2_sel", 32'(alu_sel), 32'(sel));
      check("exec2_a", 32'(alu_a), 32'(a));
      @(negedge clk);
      chk_iso("cap");
      check("cap_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      chk_iso("resp");
      check("resp_valid_c4", 32'(rsp_valid), 32'd1);
      collect("op");
    end
  endtask

  initial begin
    int last_cyc;
    exp_t e;

    // reset state
    repeat (3) @(negedge clk);
    set_req(0, 2'b01, 4'd1, 4'd1);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    chk_iso("rst");
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b1;

    // single-requester operations, including subtraction wrap and divide-by-zero
    run_op(0, 2'b00, 4'd3,  4'd5,  4'b1000);
    run_op(1, 2'b01, 4'd15, 4'd15, 4'b0100);
    run_op(2, 2'b10, 4'd13, 4'd4,  4'b0010);
    run_op(3, 2'b11, 4'd3,  4'd5,  4'b0001);
    run_op(2, 2'b10, 4'd7,  4'd0,  4'b0000);

    // response back-pressure with a competing request pending
    push_exp(1, 2'b00, 4'd15, 4'd15);
    push_exp(0, 2'b11, 4'd2, 4'd9);
    @(negedge clk);
    set_req(1, 2'b00, 4'd15, 4'd15);
    #1;
    check("stall_gnt", 32'(gnt), 32'b0010);
    @(negedge clk);
    req[1] = 1'b0;
    set_req(0, 2'b11, 4'd2, 4'd9);
    @(negedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    @(negedge clk);
    check("stall_valid_c4", 32'(rsp_valid), 32'd1);
    collect("stall");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_hold_valid", 32'(rsp_valid), 32'd1);
      check("stall_hold_data", 32'(rsp_data), 32'hE1);
      check("stall_hold_id", 32'(rsp_id), 32'd1);
      check("stall_no_gnt", 32'(gnt), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_stall_gnt", 32'(gnt), 32'b0001);
    check("post_stall_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    req[0] = 1'b0;
    for (int t = 0; t < 8 && !rsp_valid; t++) @(negedge clk);
    check("post_stall_rsp", 32'(rsp_valid), 32'd1);
    collect("post_stall");

    // asynchronous reset during EXEC2 aborts the operation
    @(negedge clk);
    set_req(3, 2'b01, 4'd5, 4'd6);
    #1;
    check("abort_gnt", 32'(gnt), 32'b1000);
    @(negedge clk);
    @(negedge clk);
    check("abort_exec2_sel", 32'(alu_sel), 32'b0100);
    rst = 1'b0;
    #1;
    chk_iso("abort");
    check("abort_gnt0", 32'(gnt), 32'd0);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_id", 32'(rsp_id), 32'd0);
    check("abort_data", 32'(rsp_data), 32'd0);
    check("abort_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    check("abort_hold_gnt", 32'(gnt), 32'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // all requesters held: round-robin from req0, five cycles apart
    for (int i = 0; i < 4; i++) set_req(i, 2'b01, 4'(i + 1), 4'(2 * i + 3));
    push_exp(0, 2'b01, 4'd1, 4'd3);
    push_exp(1, 2'b01, 4'd2, 4'd5);
    push_exp(2, 2'b01, 4'd3, 4'd7);
    push_exp(3, 2'b01, 4'd4, 4'd9);
    push_exp(0, 2'b01, 4'd1, 4'd3);
    #1;
    last_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      for (int t = 0; t < 12 && !(|gnt); t++) @(negedge clk);
      e = sbq[0];
      check("rr_gnt", 32'(gnt), 32'(1 << e.id));
      if (k > 0) check("rr_spacing", 32'(cycle - last_cyc), 32'd5);
      last_cyc = cycle;
      @(negedge clk);
      for (int t = 0; t < 12 && !rsp_valid; t++) @(negedge clk);
      check("rr_valid", 32'(rsp_valid), 32'd1);
      collect("rr");
      @(negedge clk);
    end
    req = '0;
    repeat (6) @(negedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    check("final_valid", 32'(rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
